// File: rtl/cpu_defs.sv
// Shared CPU definitions: CP0 write operations, exception record layout,
// MIPS ExcCodes, m_exc flag bit positions and default exception vectors.
package cpu_defs;

    // Default entry points for general exceptions and TLB refill
    localparam logic [31:0] EXC_VECTOR_DEF    = 32'hBFC0_0380;
    localparam logic [31:0] REFILL_VECTOR_DEF = 32'hBFC0_0200;

    // MIPS ExcCode values written into Cause.ExcCode
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Bit positions inside the 10-bit m_exc flag vector
    localparam int EB_IF_ADEL      = 9;
    localparam int EB_IF_TLBREFILL = 8;
    localparam int EB_IF_TLBINV    = 7;
    localparam int EB_RI           = 6;
    localparam int EB_OV           = 5;
    localparam int EB_SYS          = 4;
    localparam int EB_BP           = 3;
    localparam int EB_D_ADEL       = 2;
    localparam int EB_D_ADES       = 1;
    localparam int EB_D_TLB        = 0;

    // Kind of CP0 update requested by the exception controller
    typedef enum logic [2:0] {
        CP0_NONE  = 3'd0,
        CP0_EXC   = 3'd1,
        CP0_BADVA = 3'd2,
        CP0_TLB   = 3'd3,
        CP0_ERET  = 3'd4
    } cp0_op_t;

    // Exception record handed to CP0 together with the write strobe
    typedef struct packed {
        logic [4:0]  exc_code;
        logic        cause_bd;
        logic [31:0] epc;
        logic [31:0] badvaddr;
    } exc_info_t;

    // Exception controller sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REDIR  = 2'd3
    } exc_state_t;

    // A delay-slot instruction restarts at its branch, one word earlier
    function automatic logic [31:0] exc_epc(input logic [31:0] pc, input logic is_bd);
        return is_bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Exception priority encoder: picks the highest-priority pending cause and
// returns its ExcCode, CP0 write type, bad address and TLB-refill flag.
module exc_prio_enc
    import cpu_defs::*;
(
    input  logic        int_p_i,
    input  logic [9:0]  exc_i,
    input  logic        d_store_i,
    input  logic        d_refill_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] badvaddr_i,
    output logic        hit_o,
    output logic [4:0]  code_o,
    output cp0_op_t     wtype_o,
    output logic [31:0] badvaddr_o,
    output logic        refill_o
);

    // Fixed-priority selection; fetch faults report the PC, data faults the data address
    always_comb begin
        hit_o      = 1'b1;
        code_o     = EXC_INT;
        wtype_o    = CP0_NONE;
        badvaddr_o = 32'd0;
        refill_o   = 1'b0;
        if (int_p_i) begin
            code_o  = EXC_INT;
            wtype_o = CP0_EXC;
        end else if (exc_i[EB_IF_ADEL]) begin
            code_o     = EXC_ADEL;
            wtype_o    = CP0_BADVA;
            badvaddr_o = pc_i;
        end else if (exc_i[EB_IF_TLBREFILL] || exc_i[EB_IF_TLBINV]) begin
            code_o     = EXC_TLBL;
            wtype_o    = CP0_TLB;
            badvaddr_o = pc_i;
            refill_o   = exc_i[EB_IF_TLBREFILL];
        end else if (exc_i[EB_RI]) begin
            code_o  = EXC_RI;
            wtype_o = CP0_EXC;
        end else if (exc_i[EB_OV]) begin
            code_o  = EXC_OV;
            wtype_o = CP0_EXC;
        end else if (exc_i[EB_SYS]) begin
            code_o  = EXC_SYS;
            wtype_o = CP0_EXC;
        end else if (exc_i[EB_BP]) begin
            code_o  = EXC_BP;
            wtype_o = CP0_EXC;
        end else if (exc_i[EB_D_ADEL]) begin
            code_o     = EXC_ADEL;
            wtype_o    = CP0_BADVA;
            badvaddr_o = badvaddr_i;
        end else if (exc_i[EB_D_ADES]) begin
            code_o     = EXC_ADES;
            wtype_o    = CP0_BADVA;
            badvaddr_o = badvaddr_i;
        end else if (exc_i[EB_D_TLB]) begin
            code_o     = d_store_i ? EXC_TLBS : EXC_TLBL;
            wtype_o    = CP0_TLB;
            badvaddr_o = badvaddr_i;
            refill_o   = d_refill_i;
        end else begin
            hit_o = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: captures a MEM-stage exception or ERET, commits it to
// CP0 with a single write strobe, waits for CP0 read data to settle and then
// redirects fetch to the handler vector or to EPC.
//
// Handshake: cp0_wen is a one-cycle strobe (no back-pressure); cp0_rready is a
// level input sampled only while waiting; redirect_valid is a one-cycle pulse
// that carries redirect_pc and needs no acknowledge.
module exc_ctrl
    import cpu_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEF,
    parameter logic [31:0] REFILL_VECTOR = REFILL_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_is_bd,
    input  logic [31:0] m_badvaddr,
    input  logic [9:0]  m_exc,
    input  logic        m_d_store,
    input  logic        m_d_refill,
    input  logic        m_eret,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    input  logic        cp0_rready,
    output logic        cp0_wen,
    output cp0_op_t     cp0_wtype,
    output exc_info_t   cp0_exc_info,
    output logic        flush,
    output logic        stall_req,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [1:0]  dbg_state
);

    exc_state_t state_q, state_d;

    logic       int_p_q, int_p_d;
    cp0_op_t    wtype_q, wtype_d;
    exc_info_t  info_q, info_d;
    logic       refill_q, refill_d;
    logic       exl_q, exl_d;
    logic       eret_q, eret_d;

    logic        enc_hit;
    logic [4:0]  enc_code;
    cp0_op_t     enc_wtype;
    logic [31:0] enc_badvaddr;
    logic        enc_refill;
    logic        capture;

    // Status/Cause bits that do not take part in interrupt detection
    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};

    assign dbg_state = state_q;

    exc_prio_enc u_prio_enc (
        .int_p_i    (int_p_q),
        .exc_i      (m_exc),
        .d_store_i  (m_d_store),
        .d_refill_i (m_d_refill),
        .pc_i       (m_pc),
        .badvaddr_i (m_badvaddr),
        .hit_o      (enc_hit),
        .code_o     (enc_code),
        .wtype_o    (enc_wtype),
        .badvaddr_o (enc_badvaddr),
        .refill_o   (enc_refill)
    );

    // Only a valid MEM instruction in IDLE can start a sequence
    assign capture = (state_q == ST_IDLE) && m_valid && (enc_hit || m_eret);

    // Interrupt pending: enabled, not at exception level, some unmasked line raised
    always_comb begin
        int_p_d = cp0_status[0] & ~cp0_status[1] & (|(cp0_status[15:8] & cp0_cause[15:8]));
    end

    // Next values of the latched event; an exception always beats a same-cycle ERET
    always_comb begin
        wtype_d  = wtype_q;
        info_d   = info_q;
        refill_d = refill_q;
        exl_d    = exl_q;
        eret_d   = eret_q;
        if (capture) begin
            exl_d = cp0_status[1];
            if (enc_hit) begin
                wtype_d  = enc_wtype;
                info_d   = '{exc_code: enc_code,
                             cause_bd: m_is_bd,
                             epc:      exc_epc(m_pc, m_is_bd),
                             badvaddr: enc_badvaddr};
                refill_d = enc_refill;
                eret_d   = 1'b0;
            end else begin
                wtype_d  = CP0_ERET;
                info_d   = '0;
                refill_d = 1'b0;
                eret_d   = 1'b1;
            end
        end
    end

    // State register, interrupt-pending register and event latches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            int_p_q  <= 1'b0;
            wtype_q  <= CP0_NONE;
            info_q   <= '0;
            refill_q <= 1'b0;
            exl_q    <= 1'b0;
            eret_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            int_p_q  <= int_p_d;
            wtype_q  <= wtype_d;
            info_q   <= info_d;
            refill_q <= refill_d;
            exl_q    <= exl_d;
            eret_q   <= eret_d;
        end
    end

    // Next-state and output decode; every output idles at zero / NONE
    always_comb begin
        state_d        = state_q;
        cp0_wen        = 1'b0;
        cp0_wtype      = CP0_NONE;
        cp0_exc_info   = '0;
        flush          = 1'b0;
        stall_req      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                cp0_wen      = 1'b1;
                cp0_wtype    = wtype_q;
                cp0_exc_info = info_q;
                flush        = 1'b1;
                stall_req    = 1'b1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                stall_req = 1'b1;
                if (cp0_rready) begin
                    state_d = ST_REDIR;
                end
            end
            ST_REDIR: begin
                redirect_valid = 1'b1;
                if (eret_q) begin
                    redirect_pc = cp0_epc;
                end else if (refill_q && !exl_q) begin
                    redirect_pc = REFILL_VECTOR;
                end else begin
                    redirect_pc = EXC_VECTOR;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
